dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (dmem) between the MEM stage (CPU port) and a DMA/debug master.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU MEM-stage, DMA/debug and dmem signals around the data-memory arbiter.
// The arbiter takes the slave view; the environment driving CPU/DMA/dmem takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_valid;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ready;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   conflict_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rdata, dma_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rdata, dma_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has fixed priority, DMA is forced through after MAX_WAIT
// consecutive denied cycles (stalling the pipeline), plus a saturating conflict counter.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_PRI   = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] MAX_WAIT_M1 = 4'(MAX_WAIT - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    wait_cnt_r;
    logic [3:0]    wait_cnt_next_s;
    logic          own_cpu_raw_s;
    logic          own_dma_raw_s;
    logic          stall_raw_s;
    logic          own_cpu_s;
    logic          own_dma_s;
    logic          dma_read_s;
    logic [DW-1:0] dma_rdata_r;
    logic          dma_rvalid_r;
    logic [15:0]   conflict_cnt_r;

    // Ownership decode from the current arbitration state
    always_comb begin
        own_cpu_raw_s = 1'b0;
        own_dma_raw_s = 1'b0;
        stall_raw_s   = 1'b0;
        case (state_r)
            ST_PRI: begin
                if (bus.cpu_req) begin
                    own_cpu_raw_s = 1'b1;
                end else begin
                    own_dma_raw_s = bus.dma_valid;
                end
            end
            ST_FORCE: begin
                // A forced cycle without a DMA request leaves dmem idle but still stalls the CPU
                own_dma_raw_s = bus.dma_valid;
                stall_raw_s   = bus.cpu_req;
            end
            default: begin
                own_cpu_raw_s = 1'b0;
                own_dma_raw_s = 1'b0;
                stall_raw_s   = 1'b0;
            end
        endcase
    end

    // Nothing is granted and nothing stalls while reset is asserted
    assign own_cpu_s  = reset_n & own_cpu_raw_s;
    assign own_dma_s  = reset_n & own_dma_raw_s;
    assign dma_read_s = own_dma_s & ~bus.dma_we;

    assign bus.cpu_stall = reset_n & stall_raw_s;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_ready = own_dma_s;
    assign bus.mem_we    = own_cpu_s ? bus.cpu_we : (own_dma_s ? bus.dma_we : 1'b0);
    assign bus.mem_addr  = own_dma_s ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_wdata = own_dma_s ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.dma_rdata    = dma_rdata_r;
    assign bus.dma_rvalid   = dma_rvalid_r;
    assign bus.conflict_cnt = conflict_cnt_r;

    // Starvation tracking: count denied DMA cycles, force a grant after MAX_WAIT of them
    always_comb begin
        state_next_s    = ST_PRI;
        wait_cnt_next_s = 4'd0;
        if (bus.dma_valid && !own_dma_s) begin
            wait_cnt_next_s = wait_cnt_r + 4'd1;
            if (wait_cnt_r >= MAX_WAIT_M1) begin
                state_next_s = ST_FORCE;
            end else begin
                state_next_s = ST_PRI;
            end
        end else begin
            wait_cnt_next_s = 4'd0;
            state_next_s    = ST_PRI;
        end
    end

    // Arbitration state and wait counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_PRI;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // DMA read return path, one cycle after acceptance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dma_rvalid_r <= 1'b0;
            dma_rdata_r  <= {DW{1'b0}};
        end else begin
            dma_rvalid_r <= dma_read_s;
            if (dma_read_s) begin
                dma_rdata_r <= bus.mem_rdata;
            end else begin
                dma_rdata_r <= dma_rdata_r;
            end
        end
    end

    // Saturating count of cycles where both masters want dmem
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conflict_cnt_r <= 16'd0;
        end else if (bus.cpu_req && bus.dma_valid && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem (async read, posedge write).
module tb_dmem_arbiter;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:255];

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.dma_valid = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'h0;
        bus.dma_wdata = 32'h0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();

        // 1: reset blocks all grants even with both masters requesting
        reset_n       = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.dma_valid = 1'b1;
        #1;
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_dma_ready", 32'(bus.dma_ready), 32'h0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        idle();
        #1;
        check("rst_dma_rvalid", 32'(bus.dma_rvalid),   32'h0);
        check("rst_conflict",   32'(bus.conflict_cnt), 32'h0);

        // 2: DMA-only write then read of 0x40
        bus.dma_valid = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h40;
        bus.dma_wdata = 32'hDEADBEEF;
        #1;
        check("dma_wr_ready", 32'(bus.dma_ready), 32'h1);
        check("dma_wr_mem_we", 32'(bus.mem_we),   32'h1);
        check("dma_wr_addr",  bus.mem_addr,       32'h40);
        tick();
        bus.dma_we = 1'b0;
        #1;
        check("dma_wr_no_rvalid", 32'(bus.dma_rvalid), 32'h0);
        check("dma_rd_ready",     32'(bus.dma_ready),  32'h1);
        check("dma_rd_mem_we",    32'(bus.mem_we),     32'h0);
        check("dma_rd_memdata",   bus.cpu_rdata,       32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("dma_rd_rvalid", 32'(bus.dma_rvalid), 32'h1);
        check("dma_rd_rdata",  bus.dma_rdata,       32'hDEADBEEF);
        tick();
        check("dma_rvalid_pulse", 32'(bus.dma_rvalid), 32'h0);

        // 3: starvation -- four denied cycles, forced cycle 4, CPU back in cycle 5
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 32'h0;
        bus.dma_valid = 1'b1;
        bus.dma_addr  = 32'h80;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("starve_ready_c%0d", c), 32'(bus.dma_ready), 32'h0);
            check($sformatf("starve_stall_c%0d", c), 32'(bus.cpu_stall), 32'h0);
            tick();
        end
        #1;
        check("force_ready", 32'(bus.dma_ready), 32'h1);
        check("force_stall", 32'(bus.cpu_stall), 32'h1);
        check("force_addr",  bus.mem_addr,       32'h80);
        tick();
        #1;
        check("after_force_ready",  32'(bus.dma_ready),  32'h0);
        check("after_force_stall",  32'(bus.cpu_stall),  32'h0);
        check("after_force_addr",   bus.mem_addr,        32'h0);
        check("after_force_rvalid", 32'(bus.dma_rvalid), 32'h1);
        tick();
        check("starve_conflict", 32'(bus.conflict_cnt), 32'd6);
        idle();
        tick();

        // 4: CPU store then load of 0x10
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h10;
        bus.cpu_wdata = 32'h1234;
        #1;
        check("cpu_st_mem_we", 32'(bus.mem_we),    32'h1);
        check("cpu_st_addr",   bus.mem_addr,       32'h10);
        check("cpu_st_stall",  32'(bus.cpu_stall), 32'h0);
        tick();
        bus.cpu_we = 1'b0;
        #1;
        check("cpu_ld_mem_we", 32'(bus.mem_we),    32'h0);
        check("cpu_ld_rdata",  bus.cpu_rdata,      32'h1234);
        check("cpu_ld_stall",  32'(bus.cpu_stall), 32'h0);
        tick();
        idle();
        tick();

        // 5: reset asserted in the forced cycle (DMA write) suppresses the access
        bus.cpu_req   = 1'b1;
        bus.dma_valid = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h80;
        bus.dma_wdata = 32'h5555;
        for (int c = 0; c < 4; c++) tick();
        reset_n = 1'b0;
        #1;
        check("rstforce_mem_we", 32'(bus.mem_we),    32'h0);
        check("rstforce_ready",  32'(bus.dma_ready), 32'h0);
        check("rstforce_stall",  32'(bus.cpu_stall), 32'h0);
        tick();
        reset_n    = 1'b1;
        bus.dma_we = 1'b0;
        #1;
        check("rstforce_rvalid", 32'(bus.dma_rvalid), 32'h0);
        // Back in PRI with a cleared wait count: a full four denied cycles before the next force
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("rstforce_pri_c%0d", c), 32'(bus.dma_ready), 32'h0);
            tick();
        end
        #1;
        check("rstforce_reforce", 32'(bus.dma_ready), 32'h1);
        check("rstforce_restall", 32'(bus.cpu_stall), 32'h1);
        idle();
        tick();

        // 6: conflict counter saturation, starting from a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n       = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.dma_valid = 1'b1;
        bus.dma_addr  = 32'h80;
        for (int c = 0; c < 65534; c++) tick();
        check("sat_fffe", 32'(bus.conflict_cnt), 32'h0000FFFE);
        tick();
        check("sat_ffff", 32'(bus.conflict_cnt), 32'h0000FFFF);
        for (int c = 65535; c < 70000; c++) tick();
        check("sat_hold", 32'(bus.conflict_cnt), 32'h0000FFFF);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
